sha256_compress: RTL and testbench

Iterative SHA-256 compression engine. It sits directly downstream of w_generator and consumes the Wj it produces.
- Accepts one padded 512-bit block over a valid/ready handshake.
- Runs one round per clock for 64 clocks, driving the round index j into an internal w_generator instance.
- Adds the working variables into the chaining state and presents the 256-bit digest over a second valid/ready handshake.
- Multi-block messages chain through the internal hash state, controlled by blk_first.

---
 rtl/sha256_pkg.sv | 49 ++++
 rtl/w_generator.sv | 25 ++
 rtl/sha256_compress.sv | 113 +++++++++++
 tb/tb_sha256_compress.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, controller state type and round helper functions
// for the iterative compression engine and its message schedule.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [255:0] IV_DEFAULT =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/w_generator.sv
// Combinational SHA-256 message schedule: expands a 512-bit block and
// selects schedule word Wj for round index j.
module w_generator
  import sha256_pkg::*;
(
  input  logic [5:0]   j,
  input  logic [511:0] data_in,
  output logic [31:0]  wj
);

  logic [31:0] w_sched [64];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_sched[i] = data_in[511 - 32*i -: 32];
    end
    for (int i = 16; i < 64; i++) begin
      w_sched[i] = small_sigma1(w_sched[i-2]) + w_sched[i-7]
                 + small_sigma0(w_sched[i-15]) + w_sched[i-16];
    end
  end

  assign wj = w_sched[j];

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per clock, chaining hash state
// across blocks, digest presented over a valid/ready handshake.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter logic [255:0] IV = IV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic         blk_first,
  input  logic [511:0] block_in,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         busy
);

  state_t       state_reg, state_next;
  logic [5:0]   cnt_reg;
  logic [511:0] block_reg;
  logic [31:0]  h_reg [8];
  logic [31:0]  v_reg [8];
  logic [255:0] digest_reg;
  logic [255:0] h_sum;
  logic [31:0]  wj, t1, t2;

  w_generator u_wgen (
    .j       (cnt_reg),
    .data_in (block_reg),
    .wj      (wj)
  );

  // v_reg[0..7] hold working variables a..h
  assign t1 = v_reg[7] + big_sigma1(v_reg[4]) + ch(v_reg[4], v_reg[5], v_reg[6])
            + K[cnt_reg] + wj;
  assign t2 = big_sigma0(v_reg[0]) + maj(v_reg[0], v_reg[1], v_reg[2]);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hsum
      assign h_sum[255 - 32*gi -: 32] = h_reg[gi] + v_reg[gi];
    end
  endgenerate

  assign blk_ready = (state_reg == IDLE);
  assign dig_valid = (state_reg == DONE);
  assign busy      = (state_reg == ROUND) || (state_reg == FINAL);
  assign digest    = digest_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (blk_valid)         state_next = ROUND;
      ROUND:   if (cnt_reg == 6'd63)  state_next = FINAL;
      FINAL:                          state_next = DONE;
      DONE:    if (dig_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 6'd0;
      block_reg  <= '0;
      digest_reg <= '0;
      for (int i = 0; i < 8; i++) begin
        h_reg[i] <= IV[255 - 32*i -: 32];
        v_reg[i] <= 32'd0;
      end
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (blk_valid) begin
            block_reg <= block_in;
            cnt_reg   <= 6'd0;
            // A first block restarts from IV regardless of the retained chain
            for (int i = 0; i < 8; i++) begin
              if (blk_first) begin
                h_reg[i] <= IV[255 - 32*i -: 32];
                v_reg[i] <= IV[255 - 32*i -: 32];
              end else begin
                v_reg[i] <= h_reg[i];
              end
            end
          end
        end
        ROUND: begin
          v_reg[0] <= t1 + t2;
          v_reg[1] <= v_reg[0];
          v_reg[2] <= v_reg[1];
          v_reg[3] <= v_reg[2];
          v_reg[4] <= v_reg[3] + t1;
          v_reg[5] <= v_reg[4];
          v_reg[6] <= v_reg[5];
          v_reg[7] <= v_reg[6];
          cnt_reg  <= cnt_reg + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) begin
            h_reg[i] <= h_sum[255 - 32*i -: 32];
          end
          digest_reg <= h_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Scoreboard bench for sha256_compress: known-answer vectors plus random
// blocks checked against a bench-side SHA-256 compression model.
module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic [511:0] block_in;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] digest;
  logic         busy;

  sha256_compress dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .block_in  (block_in),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digest    (digest),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  bit   [31:0]  kt [64];
  logic [255:0] iv_ref;
  logic [255:0] model_h;
  logic [255:0] exp_q [$];
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] tror(input bit [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // floor(p^(1/deg) * 2^32) by bit-wise search, keeping the low 32 bits
  function automatic bit [31:0] frac_root(input int p, input int deg);
    logic [159:0] x, cand, tgt, pw;
    x   = '0;
    tgt = 160'(p) << (32 * deg);
    for (int b = 47; b >= 0; b--) begin
      cand = x | (160'(1) << b);
      pw   = (deg == 3) ? cand * cand * cand : cand * cand;
      if (pw <= tgt) x = cand;
    end
    return x[31:0];
  endfunction

  task automatic build_tables();
    int p, cnt;
    bit prime;
    p = 2; cnt = 0;
    while (cnt < 64) begin
      prime = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 1'b0;
      if (prime) begin
        kt[cnt] = frac_root(p, 3);
        if (cnt < 8) iv_ref[255 - 32*cnt -: 32] = frac_root(p, 2);
        cnt++;
      end
      p++;
    end
  endtask

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    bit [31:0] w [64];
    bit [31:0] v [8];
    bit [31:0] s0, s1, t1, t2;
    logic [255:0] hout;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = tror(w[i-15], 7) ^ tror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = tror(w[i-2], 17) ^ tror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int j = 0; j < 64; j++) begin
      s1 = tror(v[4], 6) ^ tror(v[4], 11) ^ tror(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[j] + w[j];
      s0 = tror(v[0], 2) ^ tror(v[0], 13) ^ tror(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int k = 7; k > 0; k--) v[k] = v[k-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return hout;
  endfunction

  // Monitor: every cycle a digest is presented it must match the queue head
  always @(negedge clk) begin
    if (!rst && dig_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_digest: got %h expected none", digest);
      end else if (dig_ready) begin
        check("digest", digest, exp_q.pop_front());
      end else begin
        check("digest_hold", digest, exp_q[0]);
      end
    end
  end

  task automatic send(input logic [511:0] b, input bit first, input bit use_const, input logic [255:0] cval);
    int guard;
    guard     = 0;
    blk_valid = 1'b1;
    block_in  = b;
    blk_first = first;
    @(negedge clk);
    while (!blk_ready && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (!blk_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got blk_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    if (first) model_h = iv_ref;
    model_h = ref_compress(model_h, b);
    exp_q.push_back(use_const ? cval : model_h);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && blk_ready) && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    check("drain_queue", 256'(exp_q.size()), 256'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_h = iv_ref;
  endtask

  initial begin
    int n;
    logic [511:0] rb;
    rst = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; block_in = '0; dig_ready = 1'b1;
    build_tables();
    model_h = iv_ref;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_blk_ready", 256'(blk_ready), 256'd1);
    check("reset_dig_valid", 256'(dig_valid), 256'd0);
    check("reset_busy", 256'(busy), 256'd0);
    check("reset_digest", digest, 256'd0);

    // abc with latency measurement
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    check("busy_in_round", 256'(busy), 256'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dig_valid && n < 200);
    check("latency", 256'(n), 256'd66);
    @(posedge clk); #1;
    wait_idle();

    send(BLK_EMPTY, 1'b1, 1'b1, DIG_EMPTY);
    wait_idle();

    send(BLK_TWO1, 1'b1, 1'b0, '0);
    send(BLK_TWO2, 1'b0, 1'b1, DIG_TWO);
    wait_idle();

    // Consumer stall with a block offered meanwhile
    dig_ready = 1'b0;
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dig_valid && n < 200);
    check("stall_dig_valid_seen", 256'(dig_valid), 256'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      blk_valid = 1'b1;
      blk_first = 1'b1;
      block_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("stall_blk_ready", 256'(blk_ready), 256'd0);
      check("stall_dig_valid", 256'(dig_valid), 256'd1);
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;
    dig_ready = 1'b1;
    @(posedge clk); #1;
    check("release_dig_valid", 256'(dig_valid), 256'd0);
    check("release_blk_ready", 256'(blk_ready), 256'd1);
    check("release_busy", 256'(busy), 256'd0);
    check("release_queue", 256'(exp_q.size()), 256'd0);

    // Reset during round 30 discards the block
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    repeat (30) @(posedge clk);
    #1;
    do_reset();
    check("midrst_blk_ready", 256'(blk_ready), 256'd1);
    check("midrst_dig_valid", 256'(dig_valid), 256'd0);
    check("midrst_busy", 256'(busy), 256'd0);
    check("midrst_digest", digest, 256'd0);
    repeat (70) begin
      @(negedge clk);
      if (dig_valid) check("midrst_no_digest", 256'(dig_valid), 256'd0);
    end
    @(posedge clk); #1;
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    wait_idle();

    // First-block IV reload ignores the chained state
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    send(BLK_EMPTY, 1'b1, 1'b1, DIG_EMPTY);
    wait_idle();

    // Random multi-block chains, back to back
    for (int m = 0; m < 8; m++) begin
      rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send(rb, (m == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, '0);
    end
    wait_idle();

    // After reset H equals IV, so a non-first block still starts from IV
    do_reset();
    send(BLK_ABC, 1'b0, 1'b1, DIG_ABC);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
